// File: rtl/jtpopeye_pkg.sv
// Shared types and defaults for the multi-lane object line shifter.
package jtpopeye_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FETCH = 2'd2,
        ST_READY = 2'd3
    } lane_st_e;

    localparam int PXLW_DEF = 8;
    localparam int BPP_DEF  = 2;
endpackage

// File: rtl/jtpopeye_objn_lane.sv
// One object lane: descriptor, fetch state, staging word and the bit-plane shifter.
//   state    | meaning
//   ST_IDLE  | nothing to show at the next boundary
//   ST_PEND  | descriptor written, waiting for a ROM grant
//   ST_FETCH | request granted, waiting for rom_ok
//   ST_READY | staging holds data, loads at the next boundary
module jtpopeye_objn_lane
    import jtpopeye_pkg::*;
#(
    parameter int BPP  = BPP_DEF,
    parameter int PXLW = PXLW_DEF,
    parameter int PALW = 3,
    parameter int AW   = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                desc_we,
    input  logic [AW-1:0]       desc_addr,
    input  logic [PALW-1:0]     desc_pal,
    input  logic                desc_hflip,
    input  logic                grant,
    input  logic                data_ok,
    input  logic [BPP*PXLW-1:0] rom_data,
    input  logic                boundary,
    input  logic                shift,
    input  logic                hb_rise,
    input  logic                rv,
    output logic                pend,
    output logic [AW-1:0]       addr,
    output logic [BPP-1:0]      pxl,
    output logic [PALW-1:0]     pal,
    output logic                miss_evt
);
    lane_st_e            st_q, st_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [PALW-1:0]     dpal_q, dpal_d, pal_q, pal_d;
    logic                dhflip_q, dhflip_d, hflip_q, hflip_d;
    logic [BPP*PXLW-1:0] stage_q, stage_d, shf_q, shf_d;
    logic [PXLW-1:0]     plane;

    always_comb begin
        st_d     = st_q;
        addr_d   = addr_q;
        dpal_d   = dpal_q;
        dhflip_d = dhflip_q;
        stage_d  = stage_q;
        shf_d    = shf_q;
        pal_d    = pal_q;
        hflip_d  = hflip_q;
        miss_evt = 1'b0;
        plane    = '0;
        if (boundary) begin
            if (st_q == ST_READY) begin
                shf_d   = stage_q;
                pal_d   = dpal_q;
                hflip_d = dhflip_q ^ rv;
                st_d    = ST_IDLE;
            end else begin
                shf_d    = '0;
                pal_d    = '0;
                miss_evt = (st_q == ST_PEND) || (st_q == ST_FETCH);
            end
        end else if (shift) begin
            for (int p = 0; p < BPP; p++) begin
                plane = shf_q[p*PXLW +: PXLW];
                shf_d[p*PXLW +: PXLW] = hflip_q ? (plane << 1) : (plane >> 1);
            end
        end
        if (grant && st_q == ST_PEND) st_d = ST_FETCH;
        // data for a request orphaned by a rewrite or HB lands in a non-FETCH state and is dropped
        if (data_ok && st_q == ST_FETCH) begin
            stage_d = rom_data;
            st_d    = ST_READY;
        end
        if (desc_we) begin
            addr_d   = desc_addr;
            dpal_d   = desc_pal;
            dhflip_d = desc_hflip;
            st_d     = ST_PEND;
        end
        if (hb_rise) begin
            st_d  = ST_IDLE;
            shf_d = '0;
            pal_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q     <= ST_IDLE;
            addr_q   <= '0;
            dpal_q   <= '0;
            dhflip_q <= 1'b0;
            stage_q  <= '0;
            shf_q    <= '0;
            pal_q    <= '0;
            hflip_q  <= 1'b0;
        end else begin
            st_q     <= st_d;
            addr_q   <= addr_d;
            dpal_q   <= dpal_d;
            dhflip_q <= dhflip_d;
            stage_q  <= stage_d;
            shf_q    <= shf_d;
            pal_q    <= pal_d;
            hflip_q  <= hflip_d;
        end
    end

    always_comb begin
        pxl = '0;
        for (int p = 0; p < BPP; p++)
            pxl[p] = hflip_q ? shf_q[p*PXLW+PXLW-1] : shf_q[p*PXLW];
    end

    assign pend = (st_q == ST_PEND);
    assign addr = addr_q;
    assign pal  = pal_q;
endmodule

// File: rtl/jtpopeye_objn.sv
// Object lanes sharing one ROM port: round-robin arbiter, pixel counter and priority mux.
module jtpopeye_objn
    import jtpopeye_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int BPP  = BPP_DEF,
    parameter int PXLW = PXLW_DEF,
    parameter int PALW = 3,
    parameter int AW   = 13,
    localparam int LW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pxl_cen,
    input  logic                HB,
    input  logic                VB,
    input  logic                RV,
    input  logic                desc_we,
    input  logic [LW-1:0]       desc_sel,
    input  logic [AW-1:0]       desc_addr,
    input  logic [PALW-1:0]     desc_pal,
    input  logic                desc_hflip,
    output logic [AW-1:0]       rom_addr,
    output logic                rom_cs,
    input  logic                rom_ok,
    input  logic [BPP*PXLW-1:0] rom_data,
    output logic [PALW-1:0]     obj_pal,
    output logic [BPP-1:0]      obj_pxl,
    output logic                miss
);
    localparam int CW = (PXLW > 1) ? $clog2(PXLW) : 1;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hb_q, vb_q, rom_cs_q, rom_cs_d, miss_q, miss_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic [LW-1:0]   owner_q, owner_d, last_q, last_d;
    logic [PALW-1:0] obj_pal_q, obj_pal_d, win_pal;
    logic [BPP-1:0]  obj_pxl_q, obj_pxl_d, win_pxl;
    logic            boundary, shift, hb_rise, vb_rise;
    logic [NCH-1:0]  lane_we, pend, grant, data_ok, miss_evt;
    logic [AW-1:0]   lane_addr [NCH];
    logic [BPP-1:0]  lane_pxl [NCH];
    logic [PALW-1:0] lane_pal [NCH];
    int              rank, best_rank;

    assign boundary = pxl_cen && !HB && (cnt_q == CW'(PXLW-1));
    assign shift    = pxl_cen && !HB && !boundary;
    assign hb_rise  = HB && !hb_q;
    assign vb_rise  = VB && !vb_q;

    always_comb begin
        cnt_d = cnt_q;
        if (HB) cnt_d = '0;
        else if (pxl_cen) cnt_d = (cnt_q == CW'(PXLW-1)) ? '0 : cnt_q + CW'(1);
    end

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        assign lane_we[g] = desc_we && pxl_cen && (desc_sel == LW'(g));
        jtpopeye_objn_lane #(.BPP(BPP), .PXLW(PXLW), .PALW(PALW), .AW(AW)) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .desc_we    (lane_we[g]),
            .desc_addr  (desc_addr),
            .desc_pal   (desc_pal),
            .desc_hflip (desc_hflip),
            .grant      (grant[g]),
            .data_ok    (data_ok[g]),
            .rom_data   (rom_data),
            .boundary   (boundary),
            .shift      (shift),
            .hb_rise    (hb_rise),
            .rv         (RV),
            .pend       (pend[g]),
            .addr       (lane_addr[g]),
            .pxl        (lane_pxl[g]),
            .pal        (lane_pal[g]),
            .miss_evt   (miss_evt[g])
        );
    end

    // rank 1 is the lane right after the last grant, so the search wraps round-robin
    always_comb begin
        rom_cs_d   = rom_cs_q;
        rom_addr_d = rom_addr_q;
        owner_d    = owner_q;
        last_d     = last_q;
        grant      = '0;
        data_ok    = '0;
        rank       = 0;
        best_rank  = NCH + 1;
        for (int k = 0; k < NCH; k++)
            data_ok[k] = rom_cs_q && rom_ok && (owner_q == LW'(k));
        if (rom_cs_q) begin
            if (rom_ok) rom_cs_d = 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                rank = (k > int'(last_q)) ? k - int'(last_q) : k - int'(last_q) + NCH;
                if (pend[k] && rank < best_rank) begin
                    best_rank  = rank;
                    grant      = '0;
                    grant[k]   = 1'b1;
                    rom_cs_d   = 1'b1;
                    rom_addr_d = lane_addr[k];
                    owner_d    = LW'(k);
                    last_d     = LW'(k);
                end
            end
        end
    end

    always_comb begin
        win_pxl = '0;
        win_pal = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (lane_pxl[k] != '0 && lane_pal[k] != '0) begin
                win_pxl = lane_pxl[k];
                win_pal = lane_pal[k];
            end
        end
        obj_pxl_d = obj_pxl_q;
        obj_pal_d = obj_pal_q;
        if (HB || VB) begin
            obj_pxl_d = '0;
            obj_pal_d = '0;
        end else if (pxl_cen) begin
            obj_pxl_d = win_pxl;
            obj_pal_d = win_pal;
        end
        miss_d = miss_q;
        if (vb_rise) miss_d = 1'b0;
        if (|miss_evt) miss_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            hb_q       <= 1'b0;
            vb_q       <= 1'b0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            owner_q    <= '0;
            last_q     <= '0;
            obj_pal_q  <= '0;
            obj_pxl_q  <= '0;
            miss_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            hb_q       <= HB;
            vb_q       <= VB;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            obj_pal_q  <= obj_pal_d;
            obj_pxl_q  <= obj_pxl_d;
            miss_q     <= miss_d;
        end
    end

    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;
    assign obj_pal  = obj_pal_q;
    assign obj_pxl  = obj_pxl_q;
    assign miss     = miss_q;
endmodule
